// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: count mode and the
// channel map so the datapath taps and the bench agree on event positions.
package perf_pkg;

  typedef enum logic {
    PERF_WRAP = 1'b0,
    PERF_SAT  = 1'b1
  } perf_mode_t;

  localparam int PERF_BR_TOTAL    = 0;
  localparam int PERF_BR_WRONG    = 1;
  localparam int PERF_BTB_HIT     = 2;
  localparam int PERF_L2_MISS     = 3;
  localparam int PERF_L2_TOT      = 4;
  localparam int PERF_COMMIT      = 5;
  localparam int PERF_STALL_FWD   = 6;
  localparam int PERF_STALL_CACHE = 7;
  localparam int PERF_NUM_EVENTS  = 8;

  function automatic perf_mode_t perf_mode(input int saturate);
    return (saturate != 0) ? PERF_SAT : PERF_WRAP;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One counter channel: live count, snapshot copy and sticky overflow flag,
// with a one-bit-wider adder whose carry decides wrap or clamp.
module perf_counter
  import perf_pkg::*;
#(
  parameter int         CNT_WIDTH = 32,
  parameter int         INC_WIDTH = 2,
  parameter perf_mode_t MODE      = PERF_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 snap,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] snap_cnt,
  output logic                 ovf
);

  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] snap_reg;
  logic                 ovf_reg, ovf_next;
  logic [CNT_WIDTH:0]   sum;
  logic                 carry;

  always_comb begin
    sum      = {1'b0, cnt_reg} + (CNT_WIDTH + 1)'(inc);
    carry    = sum[CNT_WIDTH];
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (clear) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (enable) begin
      cnt_next = sum[CNT_WIDTH-1:0];
      if (carry) begin
        ovf_next = 1'b1;
        if (MODE == PERF_SAT) cnt_next = '1;
      end
    end
  end

  // Snapshot takes the pre-update value, so snap+clear keeps the old count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      snap_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      if (snap) snap_reg <= cnt_reg;
    end
  end

  assign cnt      = cnt_reg;
  assign snap_cnt = snap_reg;
  assign ovf      = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with per-cycle multi-event increments, snapshot and
// a registered single-port read that returns pre-update values.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 0,
  localparam int SEL_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CNT*INC_WIDTH-1:0] inc,
  input  logic                         clear,
  input  logic                         snap,
  input  logic                         rd_req,
  input  logic [SEL_W-1:0]             rd_sel,
  input  logic                         rd_snap,
  output logic                         rd_valid,
  output logic [CNT_WIDTH-1:0]         rd_data,
  output logic                         rd_ovf,
  output logic [NUM_CNT-1:0]           ovf
);

  localparam perf_mode_t MODE = perf_mode(SATURATE);

  logic [CNT_WIDTH-1:0] live_cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] sel_data;
  logic                 sel_ovf;
  logic                 rd_valid_reg;
  logic [CNT_WIDTH-1:0] rd_data_reg;
  logic                 rd_ovf_reg;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_chan
      perf_counter #(
        .CNT_WIDTH(CNT_WIDTH),
        .INC_WIDTH(INC_WIDTH),
        .MODE     (MODE)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (clear),
        .snap    (snap),
        .inc     (inc[gi*INC_WIDTH +: INC_WIDTH]),
        .cnt     (live_cnt[gi]),
        .snap_cnt(snap_cnt[gi]),
        .ovf     (ovf[gi])
      );
    end
  endgenerate

  // Unmatched selects (rd_sel >= NUM_CNT) fall through to zero data and flag.
  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_data = rd_snap ? snap_cnt[i] : live_cnt[i];
        sel_ovf  = ovf[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_ovf_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_data_reg <= sel_data;
        rd_ovf_reg  <= sel_ovf;
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_ovf   = rd_ovf_reg;

endmodule
